// File: rtl/fpu_issue_ctrl.sv
// Issue/hazard controller for the fixed-latency FP pipeline: tracks in-flight
// destinations, holds issue on RAW hazards, optional forwarding via FPU_FWD_EN.
module fpu_issue_ctrl #(
    parameter int LAT  = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [2:0]      inst_cls,
    input  logic            inst_sub,
    input  logic [4:0]      inst_rd,
    input  logic [4:0]      inst_rs1,
    input  logic [4:0]      inst_rs2,
    input  logic            use_rs1,
    input  logic            use_rs2,
    output logic            is_itof,
    output logic            is_load,
    output logic            is_adsb,
    output logic            is_mult,
    output logic            is_sub,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [2:0]      fwd1_sel,
    output logic [2:0]      fwd2_sel,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [2:0] CLS_ITOF = 3'd1;
    localparam logic [2:0] CLS_LOAD = 3'd2;
    localparam logic [2:0] CLS_ADSB = 3'd3;
    localparam logic [2:0] CLS_MULT = 3'd4;
    localparam logic [2:0] LAT_S    = 3'(LAT);
`ifdef FPU_FWD_EN
    localparam logic       FWD_EN   = 1'b1;
`else
    localparam logic       FWD_EN   = 1'b0;
`endif

    // First stage at which an entry of the given class holds its result.
    function automatic logic [2:0] ready_stage(input logic [2:0] cls);
        logic [2:0] r;
        case (cls)
            CLS_ITOF: r = 3'd1;
            CLS_LOAD: r = 3'd2;
            CLS_ADSB: r = 3'd3;
            default:  r = LAT_S;
        endcase
        return r;
    endfunction

    logic [LAT:1] stg_v_r;
    logic [4:0]   stg_rd_r  [1:LAT];
    logic [2:0]   stg_cls_r [1:LAT];

    logic       issue_s, alloc_s;
    logic       hit1_s, hit2_s, rdy1_s, rdy2_s, blk1_s, blk2_s;
    logic [2:0] sel1_s, sel2_s;

    // Source match scan: walk oldest to youngest so the youngest hit wins.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        rdy1_s = 1'b0;
        rdy2_s = 1'b0;
        sel1_s = 3'd0;
        sel2_s = 3'd0;
        for (int k = LAT; k >= 1; k--) begin
            if (use_rs1 && stg_v_r[k] && (stg_rd_r[k] == inst_rs1)) begin
                hit1_s = 1'b1;
                sel1_s = 3'(k);
                rdy1_s = (3'(k) >= ready_stage(stg_cls_r[k]));
            end else begin
                hit1_s = hit1_s;
            end
            if (use_rs2 && stg_v_r[k] && (stg_rd_r[k] == inst_rs2)) begin
                hit2_s = 1'b1;
                sel2_s = 3'(k);
                rdy2_s = (3'(k) >= ready_stage(stg_cls_r[k]));
            end else begin
                hit2_s = hit2_s;
            end
        end
    end

    // Hazard resolution; without forwarding every match blocks issue.
    always_comb begin
        blk1_s     = hit1_s & ~(FWD_EN & rdy1_s);
        blk2_s     = hit2_s & ~(FWD_EN & rdy2_s);
        fwd1_sel   = (FWD_EN & hit1_s & rdy1_s) ? sel1_s : 3'd0;
        fwd2_sel   = (FWD_EN & hit2_s & rdy2_s) ? sel2_s : 3'd0;
        inst_ready = ~(blk1_s | blk2_s);
    end

    // Issue qualification and per-class datapath strobes.
    always_comb begin
        issue_s = inst_valid & inst_ready;
        alloc_s = issue_s & (inst_cls >= CLS_ITOF) & (inst_cls <= CLS_MULT);
        is_itof = issue_s & (inst_cls == CLS_ITOF);
        is_load = issue_s & (inst_cls == CLS_LOAD);
        is_adsb = issue_s & (inst_cls == CLS_ADSB);
        is_mult = issue_s & (inst_cls == CLS_MULT);
        is_sub  = issue_s & (inst_cls == CLS_ADSB) & inst_sub;
    end

    // Tracking pipe: free-running shift, bubbles enter when nothing allocates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_v_r <= {LAT{1'b0}};
            for (int k = 1; k <= LAT; k++) begin
                stg_rd_r[k]  <= 5'd0;
                stg_cls_r[k] <= 3'd0;
            end
        end else begin
            stg_v_r      <= {stg_v_r[LAT-1:1], alloc_s};
            stg_rd_r[1]  <= alloc_s ? inst_rd : 5'd0;
            stg_cls_r[1] <= alloc_s ? inst_cls : 3'd0;
            for (int k = 2; k <= LAT; k++) begin
                stg_rd_r[k]  <= stg_rd_r[k-1];
                stg_cls_r[k] <= stg_cls_r[k-1];
            end
        end
    end

    assign wb_en = stg_v_r[LAT];
    assign wb_rd = stg_rd_r[LAT];

    // Saturating count of cycles where decode waits on a hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= {CNTW{1'b0}};
        end else if (inst_valid && !inst_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl; expectations follow FPU_FWD_EN.
module tb_fpu_issue_ctrl;

    localparam int LAT  = 5;
    localparam int CNTW = 5;
    localparam int CMAX = (1 << CNTW) - 1;
`ifdef FPU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            inst_valid, inst_ready, inst_sub, use_rs1, use_rs2;
    logic [2:0]      inst_cls;
    logic [4:0]      inst_rd, inst_rs1, inst_rs2;
    logic            is_itof, is_load, is_adsb, is_mult, is_sub, wb_en;
    logic [4:0]      wb_rd;
    logic [2:0]      fwd1_sel, fwd2_sel;
    logic [CNTW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_stall = 0;

    fpu_issue_ctrl #(.LAT(LAT), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_cls(inst_cls), .inst_sub(inst_sub), .inst_rd(inst_rd),
        .inst_rs1(inst_rs1), .inst_rs2(inst_rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .is_itof(is_itof), .is_load(is_load), .is_adsb(is_adsb), .is_mult(is_mult),
        .is_sub(is_sub), .wb_en(wb_en), .wb_rd(wb_rd), .fwd1_sel(fwd1_sel),
        .fwd2_sel(fwd2_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic s, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
        inst_valid = v; inst_cls = c; inst_sub = s; inst_rd = rd;
        inst_rs1 = r1; inst_rs2 = r2; use_rs1 = u1; use_rs2 = u2;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    function automatic int rstage(input int c);
        case (c)
            1: return 1;
            2: return 2;
            3: return 3;
            default: return LAT;
        endcase
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    // Present the consumer until it issues; returns stall cycles seen.
    task automatic wait_issue(output int stalls, output bit issued);
        stalls = 0;
        issued = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (inst_ready) begin
                issued = 1'b1;
                break;
            end
            stalls++;
            step();
        end
    endtask

    // Producer then dependent consumer one cycle later.
    task automatic dep_test(input string tag, input int pcls, input logic [4:0] prd,
                            input int ccls, input bit src2, input bit both);
        int stalls, exp_n, exp_sel;
        bit issued;
        drive(1'b1, 3'(pcls), 1'b0, prd, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        chk({tag, "_prod_ready"}, inst_ready, 1);
        step();
        if (both)      drive(1'b1, 3'(ccls), 1'b0, 5'd20, prd, prd, 1'b1, 1'b1);
        else if (src2) drive(1'b1, 3'(ccls), 1'b0, 5'd20, 5'd30, prd, 1'b1, 1'b1);
        else           drive(1'b1, 3'(ccls), 1'b0, 5'd20, prd, 5'd31, 1'b1, 1'b1);
        wait_issue(stalls, issued);
        exp_n   = FWD ? rstage(pcls) - 1 : LAT;
        exp_sel = FWD ? rstage(pcls) : 0;
        chk({tag, "_issued"}, issued, 1);
        chk({tag, "_stalls"}, stalls, exp_n);
        chk({tag, "_fwd1"}, fwd1_sel, (src2 && !both) ? 0 : exp_sel);
        chk({tag, "_fwd2"}, fwd2_sel, (src2 || both) ? exp_sel : 0);
        chk({tag, "_strobe"}, (ccls == 3) ? is_adsb : is_mult, 1);
        exp_stall = sat_add(exp_stall, exp_n);
        step();
        idle();
        repeat (LAT + 1) step();
        chk({tag, "_cnt"}, stall_cnt, exp_stall);
    endtask

    initial begin
        int cls_tab[4] = '{1, 2, 3, 4};
        int stalls, wbs;
        bit issued;

        rst_n = 1'b0;
        idle();
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        chk("rst_ready", inst_ready, 1);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_cnt", stall_cnt, 0);

        // Fill the pipe, take one stall, then reset with stages full.
        drive(1'b1, 3'd4, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0); step();
        drive(1'b1, 3'd1, 1'b0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0); step();
        drive(1'b1, 3'd2, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0); step();
        drive(1'b1, 3'd3, 1'b0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0); step();
        drive(1'b1, 3'd3, 1'b0, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0);
        #1;
        chk("fill_stall_ready", inst_ready, 0);
        step();
        #1;
        chk("fill_wb_en", wb_en, 1);
        chk("fill_wb_rd", wb_rd, 1);
        chk("fill_cnt", stall_cnt, 1);
        idle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wb_en", wb_en, 0);
        chk("mid_rst_wb_rd", wb_rd, 0);
        chk("mid_rst_ready", inst_ready, 1);
        chk("mid_rst_cnt", stall_cnt, 0);
        chk("mid_rst_fwd1", fwd1_sel, 0);
        step(); step();
        rst_n = 1'b1;
        wbs = 0;
        repeat (8) begin
            #1;
            if (wb_en) wbs++;
            step();
        end
        chk("post_rst_no_wb", wbs, 0);

        // Independent back-to-back stream.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(cls_tab[i]), (i == 2), 5'(i + 1), 5'd10, 5'd11, 1'b1, 1'b1);
            #1;
            chk("ind_ready", inst_ready, 1);
            chk("ind_itof", is_itof, (i == 0));
            chk("ind_load", is_load, (i == 1));
            chk("ind_adsb", is_adsb, (i == 2));
            chk("ind_mult", is_mult, (i == 3));
            chk("ind_sub", is_sub, (i == 2));
            step();
        end
        idle();
        for (int c = 4; c <= 9; c++) begin
            #1;
            chk("ind_wb_en", wb_en, (c >= 5 && c <= 8));
            if (c >= 5 && c <= 8) chk("ind_wb_rd", wb_rd, c - 4);
            step();
        end
        chk("ind_cnt", stall_cnt, exp_stall);

        dep_test("mult_adsb", 4, 5'd5, 3, 1'b0, 1'b0);
        dep_test("load_adsb_rs2", 2, 5'd6, 3, 1'b1, 1'b0);
        dep_test("adsb_mult", 3, 5'd7, 4, 1'b0, 1'b0);
        dep_test("load_both", 2, 5'd6, 3, 1'b0, 1'b1);

        // Nops allocate nothing: a reader of a nop's rd issues at once.
        drive(1'b1, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0); step();
        drive(1'b1, 3'd6, 1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0); step();
        drive(1'b1, 3'd3, 1'b0, 5'd22, 5'd9, 5'd9, 1'b1, 1'b1);
        #1;
        chk("nop_ready", inst_ready, 1);
        chk("nop_fwd1", fwd1_sel, 0);
        step(); idle(); repeat (LAT + 1) step();

        // Two writes to f8 in flight; youngest (mult) governs.
        drive(1'b1, 3'd1, 1'b0, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0); step();
        drive(1'b1, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0); step();
        drive(1'b1, 3'd4, 1'b0, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0); step();
        drive(1'b1, 3'd3, 1'b0, 5'd21, 5'd8, 5'd0, 1'b1, 1'b0);
        wait_issue(stalls, issued);
        chk("waw_issued", issued, 1);
        chk("waw_stalls", stalls, FWD ? LAT - 1 : LAT);
        chk("waw_fwd1", fwd1_sel, FWD ? LAT : 0);
        exp_stall = sat_add(exp_stall, FWD ? LAT - 1 : LAT);
        step(); idle(); repeat (LAT + 1) step();
        chk("waw_cnt", stall_cnt, exp_stall);

        // Drive well past 2^CNTW+3 stall cycles; counter must saturate.
        for (int j = 0; j < 9; j++) begin
            drive(1'b1, 3'd4, 1'b0, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0); step();
            drive(1'b1, 3'd3, 1'b0, 5'd13, 5'd12, 5'd0, 1'b1, 1'b0);
            wait_issue(stalls, issued);
            chk("sat_issued", issued, 1);
            exp_stall = sat_add(exp_stall, FWD ? LAT - 1 : LAT);
            step(); idle();
        end
        repeat (LAT + 1) step();
        chk("sat_model", exp_stall, CMAX);
        chk("sat_cnt", stall_cnt, CMAX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
